// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IM and DM requesters, DM first, with ack timeout.
module mem_port_arbiter #(
    parameter int memAddrWidth = 15,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    im_req,
    input  logic [memAddrWidth-1:0] im_addr,
    output logic                    im_valid,
    output logic [DATA_W-1:0]       im_rdata,
    input  logic                    dm_rd,
    input  logic [3:0]              dm_wmask,
    input  logic [memAddrWidth-1:0] dm_addr,
    input  logic [DATA_W-1:0]       dm_wdata,
    output logic                    dm_valid,
    output logic [DATA_W-1:0]       dm_rdata,
    output logic                    mem_req,
    output logic [3:0]              mem_we,
    output logic [memAddrWidth-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY_IM, BUSY_DM, RESP} state_t;
    state_t state, state_nx;
    logic owner_dm;
    logic [7:0] cnt;
    logic dm_pend, busy, time_up, done, grant;
    logic [DATA_W-1:0] rd_val;
    assign dm_pend = dm_rd | (|dm_wmask);
    assign busy    = (state == BUSY_IM) || (state == BUSY_DM);
    assign time_up = cnt == 8'(TIMEOUT - 1);
    assign done    = busy && (mem_ack || time_up);
    assign grant   = (state == IDLE) && (dm_pend || im_req);
    // ack wins over a simultaneous timeout; writes and timeouts return zero
    assign rd_val  = (mem_ack && mem_we == 4'd0) ? mem_rdata : '0;
    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    always_comb begin
        state_nx = state;
        mem_req  = busy;
        im_valid = (state == RESP) && !owner_dm;
        dm_valid = (state == RESP) && owner_dm;
        case (state)
            IDLE:             state_nx = dm_pend ? BUSY_DM : im_req ? BUSY_IM : IDLE;
            BUSY_IM, BUSY_DM: state_nx = done ? RESP : state;
            default:          state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            owner_dm    <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= '0;
            mem_wdata   <= '0;
            im_rdata    <= '0;
            dm_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= busy && !mem_ack && time_up;
            if (grant) begin
                owner_dm  <= dm_pend;
                mem_addr  <= dm_pend ? dm_addr : im_addr;
                mem_we    <= dm_pend ? dm_wmask : 4'd0;
                mem_wdata <= dm_pend ? dm_wdata : '0;
            end
            if (busy) cnt <= done ? 8'd0 : cnt + 8'd1;
            if (done && owner_dm) dm_rdata <= rd_val;
            if (done && !owner_dm) im_rdata <= rd_val;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, wait states, timeout and reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic im_req, dm_rd, mem_ack;
    logic [14:0] im_addr, dm_addr;
    logic [3:0] dm_wmask;
    logic [31:0] dm_wdata, mem_rdata;
    logic im_valid, dm_valid, mem_req, timeout_err;
    logic [31:0] im_rdata, dm_rdata, mem_wdata;
    logic [3:0] mem_we;
    logic [14:0] mem_addr;
    logic to_im_valid, to_dm_valid, to_mem_req, to_timeout_err;
    logic [31:0] to_im_rdata, to_dm_rdata, to_mem_wdata;
    logic [3:0] to_mem_we;
    logic [14:0] to_mem_addr;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter u_dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_valid(im_valid), .im_rdata(im_rdata),
        .dm_rd(dm_rd), .dm_wmask(dm_wmask), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    // short-timeout instance whose memory never acknowledges
    mem_port_arbiter #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_valid(to_im_valid), .im_rdata(to_im_rdata),
        .dm_rd(dm_rd), .dm_wmask(dm_wmask), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(to_dm_valid), .dm_rdata(to_dm_rdata),
        .mem_req(to_mem_req), .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata),
        .mem_ack(1'b0), .mem_rdata(mem_rdata), .timeout_err(to_timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; im_req = 1'b1; im_addr = 15'h0040; dm_rd = 1'b0; dm_wmask = 4'd0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        // reset with a pending IM request
        repeat (3) step();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_im_valid", 32'(im_valid), 0);
        check("rst_dm_valid", 32'(dm_valid), 0);
        check("rst_im_rdata", im_rdata, 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst = 1'b1;
        step();
        check("rel_mem_req", 32'(mem_req), 1);
        check("rel_mem_addr", 32'(mem_addr), 32'h0040);
        check("rel_mem_we", 32'(mem_we), 0);
        // zero-wait IM read
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        step();
        check("im0_valid", 32'(im_valid), 1);
        check("im0_rdata", im_rdata, 32'h00500093);
        check("im0_dm_valid", 32'(dm_valid), 0);
        check("im0_mem_req", 32'(mem_req), 0);
        im_req = 1'b0; mem_ack = 1'b0;
        step();
        check("im0_pulse_end", 32'(im_valid), 0);
        // contention: DM write wins, IM follows
        im_req = 1'b1; im_addr = 15'h0044;
        dm_wmask = 4'b0011; dm_rd = 1'b1; dm_addr = 15'h1000; dm_wdata = 32'hDEADBEEF;
        step();
        check("cont_mem_req", 32'(mem_req), 1);
        check("cont_mem_we", 32'(mem_we), 32'h3);
        check("cont_mem_addr", 32'(mem_addr), 32'h1000);
        check("cont_mem_wdata", mem_wdata, 32'hDEADBEEF);
        dm_wmask = 4'd0; dm_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        check("cont_dm_valid", 32'(dm_valid), 1);
        check("cont_dm_rdata", dm_rdata, 0);
        check("cont_im_valid", 32'(im_valid), 0);
        mem_ack = 1'b0;
        step();
        check("cont_idle_req", 32'(mem_req), 0);
        check("cont_idle_dmv", 32'(dm_valid), 0);
        step();
        check("cont_im_req", 32'(mem_req), 1);
        check("cont_im_addr", 32'(mem_addr), 32'h0044);
        check("cont_im_we", 32'(mem_we), 0);
        check("cont_im_wdata", mem_wdata, 0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        check("cont_im_valid2", 32'(im_valid), 1);
        check("cont_im_rdata", im_rdata, 32'hCAFEF00D);
        check("cont_dmv_excl", 32'(dm_valid), 0);
        im_req = 1'b0; mem_ack = 1'b0;
        step();
        // DM read with 5 busy cycles, withdrawn after grant
        dm_rd = 1'b1; dm_addr = 15'h0200;
        step();
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("ws_req_%0d", i), 32'(mem_req), 1);
            check($sformatf("ws_addr_%0d", i), 32'(mem_addr), 32'h0200);
            check($sformatf("ws_dmv_%0d", i), 32'(dm_valid), 0);
            dm_rd = 1'b0; dm_addr = 15'h7FFF;
            mem_ack = (i == 5); mem_rdata = (i == 5) ? 32'h12345678 : 32'hA5A5A5A5;
            step();
        end
        check("ws_dm_valid", 32'(dm_valid), 1);
        check("ws_dm_rdata", dm_rdata, 32'h12345678);
        check("ws_im_hold", im_rdata, 32'hCAFEF00D);
        check("ws_mem_req", 32'(mem_req), 0);
        // stray ack with no request outstanding
        mem_rdata = 32'h0BADF00D;
        step();
        check("stray_dmv", 32'(dm_valid), 0);
        check("stray_req", 32'(mem_req), 0);
        step();
        check("stray_dmv2", 32'(dm_valid), 0);
        check("stray_imv2", 32'(im_valid), 0);
        check("stray_rdata", dm_rdata, 32'h12345678);
        mem_ack = 1'b0;
        // reset during BUSY_DM
        dm_rd = 1'b1; dm_addr = 15'h0300;
        step();
        check("mid_req", 32'(mem_req), 1);
        rst = 1'b0; dm_rd = 1'b0;
        step();
        check("mid_rst_req", 32'(mem_req), 0);
        check("mid_rst_dmv", 32'(dm_valid), 0);
        check("mid_rst_rdata", dm_rdata, 0);
        rst = 1'b1; dm_wmask = 4'hF; dm_addr = 15'h0304; dm_wdata = 32'h11112222;
        step();
        check("post_req", 32'(mem_req), 1);
        check("post_we", 32'(mem_we), 32'hF);
        check("post_addr", 32'(mem_addr), 32'h0304);
        dm_wmask = 4'd0; mem_ack = 1'b1;
        step();
        check("post_dmv", 32'(dm_valid), 1);
        mem_ack = 1'b0;
        step();
        // timeout on the TIMEOUT=4 instance
        rst = 1'b0;
        step();
        rst = 1'b1; im_req = 1'b1; im_addr = 15'h0080;
        step();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req_%0d", i), 32'(to_mem_req), 1);
            check($sformatf("to_err_%0d", i), 32'(to_timeout_err), 0);
            check($sformatf("to_imv_%0d", i), 32'(to_im_valid), 0);
            step();
        end
        check("to_err", 32'(to_timeout_err), 1);
        check("to_imv", 32'(to_im_valid), 1);
        check("to_rdata", to_im_rdata, 0);
        check("to_req_low", 32'(to_mem_req), 0);
        im_req = 1'b0;
        step();
        check("to_err_end", 32'(to_timeout_err), 0);
        check("to_imv_end", 32'(to_im_valid), 0);
        check("to_idle_req", 32'(to_mem_req), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
